mem_read_initiator: RTL and testbench

- Requesting end of the testbench memory read interface: issues word-aligned read requests (`valid_o`/`addr_o`) to a fixed-latency, non-stalling memory model and collects the returned words.
- Responses arrive in order with no backpressure. The block uses credit-based issue, so every response always has FIFO space.
- Returned words are presented on a ready/valid output stream for a checker or a DUT stimulus driver.

---
 rtl/mem_read_initiator_pkg.sv | 20 ++
 rtl/mem_read_initiator_fifo.sv | 57 +++++
 rtl/mem_read_initiator.sv | 115 +++++++++++
 tb/tb_mem_read_initiator.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_initiator_pkg.sv
// Shared definitions for the memory read initiator: state encoding and the
// width helpers used to size counters and the address stride.
package mem_read_initiator_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Ceiling log2, constant-evaluable for parameter sizing.
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_read_initiator_fifo.sv
// First-word fall-through FIFO: o_data always shows the head entry.
// Simultaneous push and pop are both honoured.
module sync_fifo_fwft
  import mem_read_initiator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_pop,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [log2c(FIFO_DEPTH):0]    o_count
);

  localparam int unsigned AW = log2c(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [AW:0]           r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == DEPTH_W);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_read_initiator.sv
// Burst read requester: issues credit-limited word reads to a fixed-latency
// memory and streams the returned words out through a FWFT buffer.
module mem_read_initiator
  import mem_read_initiator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mem_valid_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_valid_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic                   stray_o
);

  localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);
  localparam int unsigned OW  = log2c(FIFO_DEPTH) + 1;
  localparam logic [OW:0] DEPTH_W = (OW+1)'(FIFO_DEPTH);

  state_t                 r_state, w_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [OW-1:0]          r_outstanding;
  logic                   r_mem_valid;
  logic                   r_stray;
  logic [OW-1:0]          w_fifo_count;
  logic [OW:0]            w_used;
  logic                   w_issue, w_push, w_pop, w_fifo_full, w_fifo_empty;

  // Credit: buffered words plus in-flight requests never exceed the FIFO depth.
  assign w_used  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_issue = (r_state == ISSUE) && (r_remaining != '0) && (w_used < DEPTH_W);
  assign w_push  = mem_valid_i && (r_outstanding != '0);
  assign w_pop   = data_valid_o && data_ready_i;

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (mem_data_i),
    .i_pop   (w_pop),
    .o_data  (data_o),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start_i) w_next = (count_i != '0) ? ISSUE : DONE;
      ISSUE: if (w_issue && (r_remaining == COUNT_WIDTH'(1))) w_next = DRAIN;
      // With nothing outstanding no push can occur, so the last pop empties it.
      DRAIN: if ((r_outstanding == '0) &&
                 (w_fifo_empty || ((w_fifo_count == OW'(1)) && w_pop)))
               w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_mem_addr    <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_mem_valid   <= 1'b0;
      r_stray       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mem_valid <= w_issue;
      if ((r_state == IDLE) && start_i) begin
        r_addr      <= base_addr_i;
        r_remaining <= count_i;
      end
      if (w_issue) begin
        r_mem_addr  <= r_addr;
        r_addr      <= r_addr + ADDR_WIDTH'(BPW);
        r_remaining <= r_remaining - COUNT_WIDTH'(1);
      end
      case ({w_issue, w_push})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (mem_valid_i && (r_outstanding == '0)) r_stray <= 1'b1;
    end
  end

  assign busy_o       = (r_state == ISSUE) || (r_state == DRAIN);
  assign done_o       = (r_state == DONE);
  assign mem_valid_o  = r_mem_valid;
  assign mem_addr_o   = r_mem_addr;
  assign data_valid_o = !w_fifo_empty;
  assign stray_o      = r_stray;

endmodule

// File: tb/tb_mem_read_initiator.sv
// Bench for mem_read_initiator: a delay-line memory model, a negedge monitor
// and an address/data reference derived from base, count and word stride.
module tb_mem_read_initiator;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset, start_i, mem_valid_i, data_ready_i;
  logic [7:0]  base_addr_i, count_i, mem_addr_o, mem_data_i, data_o;
  logic        busy_o, done_o, mem_valid_o, data_valid_o, stray_o;

  logic        wd_start, wd_busy, wd_done, wd_mvo, wd_mvi, wd_dvo, wd_dri, wd_stray;
  logic [7:0]  wd_base, wd_count, wd_mao;
  logic [31:0] wd_mdi, wd_do;

  always #5 clk = ~clk;

  mem_read_initiator #(
    .DATA_WIDTH (8), .ADDR_WIDTH (8), .COUNT_WIDTH (8), .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk), .reset (reset), .start_i (start_i), .base_addr_i (base_addr_i),
    .count_i (count_i), .busy_o (busy_o), .done_o (done_o),
    .mem_valid_o (mem_valid_o), .mem_addr_o (mem_addr_o),
    .mem_valid_i (mem_valid_i), .mem_data_i (mem_data_i), .data_o (data_o),
    .data_valid_o (data_valid_o), .data_ready_i (data_ready_i), .stray_o (stray_o)
  );

  mem_read_initiator #(
    .DATA_WIDTH (32), .ADDR_WIDTH (8), .COUNT_WIDTH (8), .FIFO_DEPTH (8)
  ) dut_w (
    .clk (clk), .reset (reset), .start_i (wd_start), .base_addr_i (wd_base),
    .count_i (wd_count), .busy_o (wd_busy), .done_o (wd_done),
    .mem_valid_o (wd_mvo), .mem_addr_o (wd_mao),
    .mem_valid_i (wd_mvi), .mem_data_i (wd_mdi), .data_o (wd_do),
    .data_valid_o (wd_dvo), .data_ready_i (wd_dri), .stray_o (wd_stray)
  );

  // Memory models: byte array with a configurable-latency delay line; the
  // wide memory answers combinationally with an address-derived pattern.
  logic [7:0] mem [256];
  int         lat = 0;
  logic       v_pipe [8] = '{default: 1'b0};
  logic [7:0] a_pipe [8] = '{default: 8'h00};

  always @(posedge clk) begin
    v_pipe[0] <= mem_valid_o;
    a_pipe[0] <= mem_addr_o;
    for (int i = 1; i < 8; i++) begin
      v_pipe[i] <= v_pipe[i-1];
      a_pipe[i] <= a_pipe[i-1];
    end
  end

  always_comb begin
    if (lat == 0) begin
      mem_valid_i = mem_valid_o;
      mem_data_i  = mem[mem_addr_o];
    end else begin
      mem_valid_i = v_pipe[lat-1];
      mem_data_i  = mem[a_pipe[lat-1]];
    end
  end

  function automatic logic [31:0] wdata(input logic [7:0] a);
    return {a, ~a, a + 8'd1, a ^ 8'h5A};
  endfunction

  assign wd_mvi = wd_mvo;
  assign wd_mdi = wdata(wd_mao);

  // Monitor
  logic [7:0]  req_q [$];
  int          req_cyc [$];
  logic [7:0]  got_q [$];
  logic [7:0]  wreq_q [$];
  logic [31:0] wgot_q [$];
  int cyc = 0, done_cnt = 0, wdone_cnt = 0, out_m = 0, out_max = 0, ovf = 0;
  int done_busy = 0, pop_cyc = 0, done_cyc = 0;
  int vec = 0, errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) out_m = 0;
    else begin
      if (mem_valid_o) begin
        req_q.push_back(mem_addr_o);
        req_cyc.push_back(cyc);
        out_m++;
      end
      if (mem_valid_i && out_m > 0) out_m--;
      if (out_m > out_max) out_max = out_m;
    end
    if (data_valid_o && data_ready_i) begin got_q.push_back(data_o); pop_cyc = cyc; end
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (done_o && busy_o) done_busy++;
    if (dut.u_fifo.i_push && dut.u_fifo.o_full) ovf++;
    if (dut_w.u_fifo.i_push && dut_w.u_fifo.o_full) ovf++;
    if (wd_mvo) wreq_q.push_back(wd_mao);
    if (wd_dvo && wd_dri) wgot_q.push_back(wd_do);
    if (wd_done) wdone_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    req_q.delete(); req_cyc.delete(); got_q.delete();
    wreq_q.delete(); wgot_q.delete();
    done_cnt = 0; wdone_cnt = 0; done_busy = 0; out_max = 0;
  endtask

  task automatic start_burst(input logic [7:0] base, input logic [7:0] cnt);
    base_addr_i = base; count_i = cnt; start_i = 1'b1;
    tick(1);
    start_i = 1'b0; base_addr_i = 8'($urandom); count_i = 8'($urandom);
  endtask

  task automatic wait_done(input string name, input int limit);
    int k;
    k = 0;
    while (done_cnt == 0 && k < limit) begin tick(1); k++; end
    vec++;
    if (done_cnt == 0) begin
      errs++;
      $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, limit);
    end
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; data_ready_i = 1'b0; wd_start = 1'b0; wd_dri = 1'b1;
    base_addr_i = '0; count_i = '0; wd_base = '0; wd_count = '0;
    tick(2);
    vec++; if ({busy_o, done_o, mem_valid_o, data_valid_o, stray_o} !== 5'b0) begin
      errs++; $display("FAIL reset_flags: got %b expected 00000",
                       {busy_o, done_o, mem_valid_o, data_valid_o, stray_o});
    end
    vec++; if (mem_addr_o !== 8'h00) begin
      errs++; $display("FAIL reset_addr: got %h expected 00", mem_addr_o);
    end
    vec++; if ({wd_busy, wd_done, wd_mvo, wd_dvo, wd_stray} !== 5'b0) begin
      errs++; $display("FAIL reset_wide_flags: got %b expected 00000",
                       {wd_busy, wd_done, wd_mvo, wd_dvo, wd_stray});
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    logic [7:0] ea;
    lat = 0; data_ready_i = 1'b1; clear_mon();
    start_burst(8'h10, 8'd4);
    wait_done("basic", 50);
    vec++; if (req_q.size() != 4) begin
      errs++; $display("FAIL basic_req_count: got %0d expected 4", req_q.size());
    end
    for (int i = 0; i < 4 && i < req_q.size(); i++) begin
      ea = 8'(32'h10 + i);
      vec++; if (req_q[i] !== ea || req_cyc[i] != req_cyc[0] + i) begin
        errs++; $display("FAIL basic_req[%0d]: got %h@%0d expected %h@%0d",
                         i, req_q[i], req_cyc[i], ea, req_cyc[0] + i);
      end
    end
    vec++; if (got_q.size() != 4) begin
      errs++; $display("FAIL basic_word_count: got %0d expected 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      ea = 8'(32'h10 + i);
      vec++; if (got_q[i] !== mem[ea]) begin
        errs++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[i], mem[ea]);
      end
    end
    vec++; if (done_cnt != 1 || done_busy != 0 || busy_o !== 1'b0) begin
      errs++; $display("FAIL basic_done: pulses %0d overlap %0d busy %b expected 1 0 0",
                       done_cnt, done_busy, busy_o);
    end
    vec++; if (done_cyc - pop_cyc < 1 || done_cyc - pop_cyc > 2) begin
      errs++; $display("FAIL basic_done_after_pop: gap %0d expected 1..2", done_cyc - pop_cyc);
    end
  endtask

  task automatic test_credit();
    logic [7:0] ea;
    lat = 3; data_ready_i = 1'b0; clear_mon();
    start_burst(8'h40, 8'd16);
    tick(20);
    vec++; if (req_q.size() != FD || mem_valid_o !== 1'b0) begin
      errs++; $display("FAIL credit_stall: got %0d reqs valid %b expected %0d reqs valid 0",
                       req_q.size(), mem_valid_o, FD);
    end
    data_ready_i = 1'b1;
    wait_done("credit", 500);
    vec++; if (got_q.size() != 16 || req_q.size() != 16) begin
      errs++; $display("FAIL credit_counts: got %0d words %0d reqs expected 16 16",
                       got_q.size(), req_q.size());
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      ea = 8'(32'h40 + i);
      vec++; if (got_q[i] !== mem[ea]) begin
        errs++; $display("FAIL credit_data[%0d]: got %h expected %h", i, got_q[i], mem[ea]);
      end
    end
    vec++; if (ovf != 0) begin
      errs++; $display("FAIL credit_overflow: got %0d pushes into full FIFO expected 0", ovf);
    end
  endtask

  task automatic test_zero_busy();
    logic [7:0] ea;
    lat = 1; data_ready_i = 1'b1; clear_mon();
    start_burst(8'h55, 8'd0);
    vec++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errs++; $display("FAIL zero_done: got done %b busy %b expected 1 0", done_o, busy_o);
    end
    tick(4);
    vec++; if (req_q.size() != 0 || done_cnt != 1 || done_o !== 1'b0) begin
      errs++; $display("FAIL zero_quiet: got %0d reqs %0d pulses done %b expected 0 1 0",
                       req_q.size(), done_cnt, done_o);
    end
    clear_mon();
    start_burst(8'h80, 8'd6);
    tick(2);
    vec++; if (busy_o !== 1'b1) begin
      errs++; $display("FAIL busy_mid: got %b expected 1", busy_o);
    end
    start_burst(8'h00, 8'd9);
    wait_done("busy", 60);
    tick(5);
    vec++; if (req_q.size() != 6 || got_q.size() != 6 || done_cnt != 1) begin
      errs++; $display("FAIL busy_counts: got %0d reqs %0d words %0d pulses expected 6 6 1",
                       req_q.size(), got_q.size(), done_cnt);
    end
    for (int i = 0; i < 6 && i < req_q.size() && i < got_q.size(); i++) begin
      ea = 8'(32'h80 + i);
      vec++; if (req_q[i] !== ea || got_q[i] !== mem[ea]) begin
        errs++; $display("FAIL busy_xfer[%0d]: got %h/%h expected %h/%h",
                         i, req_q[i], got_q[i], ea, mem[ea]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ea;
    int k, dv;
    lat = 2; data_ready_i = 1'b1; clear_mon();
    start_burst(8'h20, 8'd8);
    k = 0;
    while (req_q.size() < 3 && k < 50) begin tick(1); k++; end
    vec++; if (req_q.size() < 3) begin
      errs++; $display("FAIL rstmid_reach: got %0d reqs expected 3", req_q.size());
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    vec++; if ({busy_o, done_o, mem_valid_o, data_valid_o, stray_o} !== 5'b0 ||
               mem_addr_o !== 8'h00) begin
      errs++; $display("FAIL rstmid_outputs: got %b/%h expected 00000/00",
                       {busy_o, done_o, mem_valid_o, data_valid_o, stray_o}, mem_addr_o);
    end
    dv = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (data_valid_o !== 1'b0) dv++;
    end
    vec++; if (dv != 0 || stray_o !== 1'b1) begin
      errs++; $display("FAIL rstmid_stray: got %0d valid cycles stray %b expected 0 1",
                       dv, stray_o);
    end
    clear_mon();
    start_burst(8'h30, 8'd5);
    wait_done("rstmid_new", 60);
    vec++; if (got_q.size() != 5 || req_q.size() != 5 || stray_o !== 1'b1) begin
      errs++; $display("FAIL rstmid_new_counts: got %0d words %0d reqs stray %b expected 5 5 1",
                       got_q.size(), req_q.size(), stray_o);
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      ea = 8'(32'h30 + i);
      vec++; if (got_q[i] !== mem[ea]) begin
        errs++; $display("FAIL rstmid_new_data[%0d]: got %h expected %h", i, got_q[i], mem[ea]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] base, ea;
    int k;
    lat = 1; clear_mon(); ovf = 0;
    base = 8'($urandom);
    data_ready_i = 1'($urandom);
    start_burst(base, 8'd200);
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      data_ready_i = 1'($urandom_range(0, 1));
      tick(1); k++;
    end
    data_ready_i = 1'b1;
    vec++; if (done_cnt == 0) begin
      errs++; $display("FAIL random_timeout: done_o not seen within 3000 cycles");
    end
    tick(2);
    vec++; if (got_q.size() != 200) begin
      errs++; $display("FAIL random_word_count: got %0d expected 200", got_q.size());
    end
    for (int i = 0; i < 200 && i < got_q.size(); i++) begin
      ea = 8'(32'(base) + i);
      vec++; if (got_q[i] !== mem[ea]) begin
        errs++; $display("FAIL random_data[%0d]: got %h expected %h", i, got_q[i], mem[ea]);
      end
    end
    vec++; if (out_max > FD || ovf != 0) begin
      errs++; $display("FAIL random_outstanding: got max %0d overflow %0d expected <=%0d 0",
                       out_max, ovf, FD);
    end
  endtask

  task automatic test_wide_wrap();
    logic [7:0] ea;
    int k;
    clear_mon(); wd_dri = 1'b1;
    wd_base = 8'hF8; wd_count = 8'd4; wd_start = 1'b1;
    tick(1);
    wd_start = 1'b0;
    k = 0;
    while (wdone_cnt == 0 && k < 50) begin tick(1); k++; end
    tick(2);
    vec++; if (wreq_q.size() != 4 || wgot_q.size() != 4 || wdone_cnt != 1) begin
      errs++; $display("FAIL wide_counts: got %0d reqs %0d words %0d pulses expected 4 4 1",
                       wreq_q.size(), wgot_q.size(), wdone_cnt);
    end
    for (int i = 0; i < 4 && i < wreq_q.size() && i < wgot_q.size(); i++) begin
      ea = 8'(32'hF8 + 4 * i);
      vec++; if (wreq_q[i] !== ea || wgot_q[i] !== wdata(ea)) begin
        errs++; $display("FAIL wide_xfer[%0d]: got %h/%h expected %h/%h",
                         i, wreq_q[i], wgot_q[i], ea, wdata(ea));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_credit();
    test_zero_busy();
    test_reset_mid();
    test_random();
    test_wide_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded 1 ms");
    $fatal(1);
  end

endmodule
